axis_use_loader: RTL and testbench
==================================

# axis_use_loader

AXI-Stream slave front end that packs incoming stream beats into the Uncompressed Stream Element (USE) interface consumed by the compress-and-return stage. It buffers bytes and presents fixed-size chunks (`USEData`/`USEByteCount`) to the compressor. On packet end it flushes a short final chunk, flagged with `USEEndOfPacket`. It sits directly upstream of the compressor, one instance per USE lane.

## Interface
Parameters:
- `AXIS_BYTES`, 8: AXI-Stream data width in bytes.
- `MAX_UNCOMPRESSED_BYTES`, 34: buffer capacity in bytes; also the width of `USEData`.
- `CHUNK_BYTES`, 16: bytes presented per full chunk. Must be ≤ `MAX_UNCOMPRESSED_BYTES - AXIS_BYTES`.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `s_axis_tdata`  in  AXIS_BYTES×8  beat data; byte 0 is the first in stream order.
- `s_axis_tkeep`  in  AXIS_BYTES  byte enables; must be contiguous from bit 0.
- `s_axis_tlast`  in  1  last beat of the packet.
- `s_axis_tvalid`  in  1  beat valid.
- `s_axis_tready`  out  1  beat accepted when both `tvalid` and `tready` are high.
- `USEDataInput`  out  [MAX_UNCOMPRESSED_BYTES-1:0][7:0]  buffer contents; byte 0 is the oldest.
- `USEByteCount`  out  $clog2(MAX_UNCOMPRESSED_BYTES)  bytes offered; 0 means nothing is offered.
- `USEDataTaken`  in  1  consumer removes `USEByteCount` bytes at this edge.
- `USEEndOfPacket`  out  1  the offered chunk ends the packet.
- `protocolError`  out  1  sticky flag for a non-contiguous `tkeep`.

## Operation
- State register: `fill` (0..MAX_UNCOMPRESSED_BYTES), byte buffer `buf`, and FSM state `{ST_FILL, ST_DRAIN}`.
- Beat byte count `k` is the number of contiguous set bits of `tkeep` starting at bit 0.
  - If any set bit lies above that run, only the `k` low bytes are kept.
  - In that case `protocolError` is set and stays set until reset.
- Offer rule: `USEByteCount` is
  - `CHUNK_BYTES` if `fill ≥ CHUNK_BYTES`;
  - otherwise `fill` if state is ST_DRAIN;
  - otherwise 0.
- `USEEndOfPacket` = (state == ST_DRAIN) && (`fill ≤ CHUNK_BYTES`) && (`fill ≠ 0`).
- `s_axis_tready` = !reset && state == ST_FILL && `fill ≤ MAX_UNCOMPRESSED_BYTES - AXIS_BYTES`.
- Per edge, let `t` = `USEDataTaken ? USEByteCount : 0` and `a` = `accept ? k : 0`.
  - New `fill` = `fill - t + a`.
  - The buffer shifts down by `t`, then the accepted bytes are appended at index `fill - t`.
  - Buffer bytes at index ≥ new `fill` read as 0x00.
- `USEDataTaken` while `USEByteCount == 0` is ignored.
- FSM transitions:
  - ST_FILL → ST_DRAIN on acceptance of a beat with `tlast`, including `tkeep == 0`.
  - ST_DRAIN → ST_FILL when new `fill` == 0.
  - ST_DRAIN entered with `fill == 0` returns to ST_FILL on the next edge.
- Overflow cannot occur: `tready` guarantees that `a` fits.

## Timing
- All outputs are functions of registered state only. There is no combinational input-to-output path.
- Accepted bytes appear in `USEDataInput`/`USEByteCount` on the cycle after acceptance.
- A take frees space and updates `tready` on the cycle after the take.
- Take and accept in the same cycle are both honoured (see the `fill` arithmetic above).
- Reset values:
  - `fill`=0, state ST_FILL, `buf` all 0x00.
  - `USEByteCount`=0, `USEEndOfPacket`=0, `protocolError`=0.
  - `s_axis_tready`=0 while `reset` is high, and 1 from the first cycle after release.
- Reset asserted mid-packet discards buffered bytes immediately, without waiting for a clock edge.

## Structure
- Package `use_loader_pkg` holds:
  - the state enum `use_loader_state_t`;
  - localparams `FILL_W = $clog2(MAX_UNCOMPRESSED_BYTES+1)` and `CNT_W`;
  - the function `contig_ones(tkeep)`.
- Sub-module `axis_keep_decode` (combinational) maps `tkeep` to `{k, contiguous}` and is instantiated once.
- The shift/append datapath and FSM live in the top module.

## Test plan
1. Reset:
   - during reset: `tready`=0, `USEByteCount`=0, `protocolError`=0;
   - first cycle after release: `tready`=1.
2. Fill and backpressure, with `USEDataTaken`=0, sending full beats of bytes 0x00..0x1F:
   - after beat 2: `USEByteCount`=16 and bytes 0x00..0x0F offered;
   - beats 3 and 4 accepted, `fill`=32;
   - then `tready`=0.
3. Take from the step-2 state (fill 32), with `USEDataTaken` high for 1 cycle:
   - next cycle `USEDataInput[0]`=0x10, `USEByteCount`=16, `fill`=16;
   - `tready`=1.
4. Packet end: send a full beat, then `tlast` with `tkeep`=0x07.
   - `fill`=11, ST_DRAIN, `tready`=0, `USEByteCount`=11, `USEEndOfPacket`=1.
   - Take: `fill`=0, ST_FILL, and `tready`=1 on the following cycle.
5. Simultaneous take and accept at `fill`=16, taking 16 and accepting 8 bytes:
   - `fill`=8;
   - `USEDataInput[0]` equals the new beat's byte 0;
   - bytes 8..33 read 0x00.
6. Error and reset:
   - `tkeep`=0x05 → `k`=1, `fill` increments by 1, `protocolError`=1 and stays 1;
   - asynchronous reset mid-packet → all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/use_loader_pkg.sv
// Shared types, widths and helpers for the AXI-Stream to USE loader.
package use_loader_pkg;

  // Loader phase: collecting beats, or draining the tail of a finished packet.
  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } use_loader_state_t;

  // Default buffer geometry; the top derives its own widths from its parameters.
  localparam int unsigned DEF_MAX_UNCOMPRESSED_BYTES = 34;
  localparam int unsigned FILL_W = $clog2(DEF_MAX_UNCOMPRESSED_BYTES + 1);
  localparam int unsigned CNT_W  = $clog2(DEF_MAX_UNCOMPRESSED_BYTES);

  // Widest tkeep the helper below understands.
  localparam int unsigned MAX_KEEP_W = 64;

  // Number of consecutive set bits starting at bit 0.
  function automatic int unsigned contig_ones(input logic [MAX_KEEP_W-1:0] keep);
    int unsigned n;
    logic        run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < MAX_KEEP_W; i++) begin
      if (run && keep[i]) n = n + 1;
      else                run = 1'b0;
    end
    return n;
  endfunction

endpackage

// File: rtl/axis_keep_decode.sv
// Maps tkeep to the count of leading valid bytes and a contiguity flag.
module axis_keep_decode
  import use_loader_pkg::*;
#(
  parameter int unsigned AXIS_BYTES = 8,
  localparam int unsigned K_W       = $clog2(AXIS_BYTES + 1)
) (
  input  logic [AXIS_BYTES-1:0] tkeep,
  output logic [K_W-1:0]        k,
  output logic                  contiguous
);

  // Bytes above the leading run of ones mark a malformed beat.
  always_comb begin
    k          = K_W'(contig_ones(MAX_KEEP_W'(tkeep)));
    contiguous = ((tkeep >> k) == '0);
  end

endmodule

// File: rtl/axis_use_loader.sv
// Packs AXI-Stream beats into fixed-size USE chunks, flushing a short tail at packet end.
module axis_use_loader
  import use_loader_pkg::*;
#(
  parameter int unsigned AXIS_BYTES             = 8,
  parameter int unsigned MAX_UNCOMPRESSED_BYTES = 34,
  parameter int unsigned CHUNK_BYTES            = 16,
  localparam int unsigned BUF_FILL_W            = $clog2(MAX_UNCOMPRESSED_BYTES + 1),
  localparam int unsigned BUF_CNT_W             = $clog2(MAX_UNCOMPRESSED_BYTES),
  localparam int unsigned K_W                   = $clog2(AXIS_BYTES + 1)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [AXIS_BYTES*8-1:0]                 s_axis_tdata,
  input  logic [AXIS_BYTES-1:0]                   s_axis_tkeep,
  input  logic                                    s_axis_tlast,
  input  logic                                    s_axis_tvalid,
  output logic                                    s_axis_tready,
  output logic [MAX_UNCOMPRESSED_BYTES-1:0][7:0]  USEDataInput,
  output logic [BUF_CNT_W-1:0]                    USEByteCount,
  input  logic                                    USEDataTaken,
  output logic                                    USEEndOfPacket,
  output logic                                    protocolError
);

  localparam int unsigned READY_LIMIT = MAX_UNCOMPRESSED_BYTES - AXIS_BYTES;

  use_loader_state_t                         state_q, state_d;
  logic [BUF_FILL_W-1:0]                     fill_q, fill_d;
  logic [MAX_UNCOMPRESSED_BYTES-1:0][7:0]    buf_q, buf_d;
  logic                                      perr_q;

  logic [K_W-1:0]                            k;
  logic                                      contiguous;
  logic                                      accept;
  logic [BUF_FILL_W-1:0]                     take_n, add_n;
  logic [AXIS_BYTES-1:0][7:0]                beat;

  axis_keep_decode #(.AXIS_BYTES(AXIS_BYTES)) u_keep_decode (
    .tkeep      (s_axis_tkeep),
    .k          (k),
    .contiguous (contiguous)
  );

  // Offer, end-of-packet and ready are decoded from registered state only.
  always_comb begin
    USEByteCount   = '0;
    if (fill_q >= BUF_FILL_W'(CHUNK_BYTES)) USEByteCount = BUF_CNT_W'(CHUNK_BYTES);
    else if (state_q == ST_DRAIN)           USEByteCount = BUF_CNT_W'(fill_q);
    USEEndOfPacket = (state_q == ST_DRAIN) && (fill_q <= BUF_FILL_W'(CHUNK_BYTES)) &&
                     (fill_q != '0);
    s_axis_tready  = !reset && (state_q == ST_FILL) && (fill_q <= BUF_FILL_W'(READY_LIMIT));
    USEDataInput   = buf_q;
    protocolError  = perr_q;
  end

  // Next-state: fill arithmetic, FSM and shift/append buffer update.
  always_comb begin
    state_d = state_q;
    accept  = s_axis_tvalid && s_axis_tready;
    take_n  = USEDataTaken ? BUF_FILL_W'(USEByteCount) : '0;
    add_n   = accept ? BUF_FILL_W'(k) : '0;
    fill_d  = fill_q - take_n + add_n;
    beat    = s_axis_tdata;
    buf_d   = '0;

    case (state_q)
      ST_FILL:  if (accept && s_axis_tlast) state_d = ST_DRAIN;
      ST_DRAIN: if (fill_d == '0)           state_d = ST_FILL;
      default:                              state_d = ST_FILL;
    endcase

    for (int i = 0; i < int'(MAX_UNCOMPRESSED_BYTES); i++) begin
      int src;
      int base;
      src  = i + int'(take_n);
      base = int'(fill_q) - int'(take_n);
      if (src < int'(MAX_UNCOMPRESSED_BYTES)) buf_d[i] = buf_q[src];
      if (i >= base && i < base + int'(add_n)) buf_d[i] = beat[i - base];
      if (i >= int'(fill_d)) buf_d[i] = 8'h00;
    end
  end

  // State register; reset drops any buffered bytes immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FILL;
      fill_q  <= '0;
      buf_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      buf_q   <= buf_d;
      perr_q  <= perr_q | (accept && !contiguous);
    end
  end

endmodule

// File: tb/tb_axis_use_loader.sv
// Directed self-checking bench for axis_use_loader (8-byte beats, 34-byte buffer, 16-byte chunks).
module tb_axis_use_loader;

  logic             clk;
  logic             reset;
  logic [63:0]      s_axis_tdata;
  logic [7:0]       s_axis_tkeep;
  logic             s_axis_tlast;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic [33:0][7:0] use_data;
  logic [5:0]       use_cnt;
  logic             use_taken;
  logic             use_eop;
  logic             perr;

  int vectors;
  int miscompares;

  axis_use_loader #(
    .AXIS_BYTES(8),
    .MAX_UNCOMPRESSED_BYTES(34),
    .CHUNK_BYTES(16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .USEDataInput   (use_data),
    .USEByteCount   (use_cnt),
    .USEDataTaken   (use_taken),
    .USEEndOfPacket (use_eop),
    .protocolError  (perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for exactly one clock edge.
  task automatic send_beat(input logic [7:0] base, input logic [7:0] keep, input logic last);
    for (int j = 0; j < 8; j++) s_axis_tdata[j*8 +: 8] = base + 8'(j);
    s_axis_tkeep  = keep;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tkeep  = 8'h00;
  endtask

  // Nonzero if any byte from index lo upward is nonzero.
  function automatic logic upper_nonzero(input int lo);
    logic nz;
    nz = 1'b0;
    for (int i = lo; i < 34; i++) nz = nz | (|use_data[i]);
    return nz;
  endfunction

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    use_taken     = 1'b0;

    // Reset behaviour
    tick();
    tick();
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_cnt",    64'(use_cnt),       64'd0);
    check("rst_perr",   64'(perr),          64'd0);
    check("rst_eop",    64'(use_eop),       64'd0);
    reset = 1'b0;
    tick();
    check("rel_tready", 64'(s_axis_tready), 64'd1);

    // Fill to 32 with no takes
    send_beat(8'h00, 8'hFF, 1'b0);
    check("b1_cnt",     64'(use_cnt),       64'd0);
    send_beat(8'h08, 8'hFF, 1'b0);
    check("b2_cnt",     64'(use_cnt),       64'd16);
    check("b2_byte0",   64'(use_data[0]),   64'h00);
    check("b2_byte15",  64'(use_data[15]),  64'h0F);
    check("b2_tready",  64'(s_axis_tready), 64'd1);
    send_beat(8'h10, 8'hFF, 1'b0);
    check("b3_tready",  64'(s_axis_tready), 64'd1);
    send_beat(8'h18, 8'hFF, 1'b0);
    check("b4_fill",    64'(dut.fill_q),    64'd32);
    check("b4_tready",  64'(s_axis_tready), 64'd0);
    check("b4_cnt",     64'(use_cnt),       64'd16);
    check("b4_byte31",  64'(use_data[31]),  64'h1F);

    // Take one chunk from fill 32
    use_taken = 1'b1;
    tick();
    use_taken = 1'b0;
    check("tk_byte0",   64'(use_data[0]),   64'h10);
    check("tk_byte15",  64'(use_data[15]),  64'h1F);
    check("tk_byte16",  64'(use_data[16]),  64'h00);
    check("tk_cnt",     64'(use_cnt),       64'd16);
    check("tk_fill",    64'(dut.fill_q),    64'd16);
    check("tk_tready",  64'(s_axis_tready), 64'd1);

    // Empty the buffer, then a packet of 8 + 3 bytes
    use_taken = 1'b1;
    tick();
    use_taken = 1'b0;
    check("empty_fill", 64'(dut.fill_q),    64'd0);
    check("empty_cnt",  64'(use_cnt),       64'd0);
    send_beat(8'h20, 8'hFF, 1'b0);
    check("p1_cnt",     64'(use_cnt),       64'd0);
    check("p1_eop",     64'(use_eop),       64'd0);
    send_beat(8'h28, 8'h07, 1'b1);
    check("pe_fill",    64'(dut.fill_q),    64'd11);
    check("pe_state",   64'(dut.state_q),   64'd1);
    check("pe_tready",  64'(s_axis_tready), 64'd0);
    check("pe_cnt",     64'(use_cnt),       64'd11);
    check("pe_eop",     64'(use_eop),       64'd1);
    check("pe_byte10",  64'(use_data[10]),  64'h2A);
    check("pe_byte11",  64'(use_data[11]),  64'h00);
    use_taken = 1'b1;
    tick();
    use_taken = 1'b0;
    check("pt_fill",    64'(dut.fill_q),    64'd0);
    check("pt_state",   64'(dut.state_q),   64'd0);
    check("pt_tready",  64'(s_axis_tready), 64'd1);
    check("pt_eop",     64'(use_eop),       64'd0);

    // Simultaneous take and accept at fill 16
    send_beat(8'h40, 8'hFF, 1'b0);
    send_beat(8'h48, 8'hFF, 1'b0);
    check("sa_pre_cnt", 64'(use_cnt),       64'd16);
    use_taken = 1'b1;
    send_beat(8'h50, 8'hFF, 1'b0);
    use_taken = 1'b0;
    check("sa_fill",    64'(dut.fill_q),    64'd8);
    check("sa_byte0",   64'(use_data[0]),   64'h50);
    check("sa_byte7",   64'(use_data[7]),   64'h57);
    check("sa_hi_zero", 64'(upper_nonzero(8)), 64'd0);
    check("sa_cnt",     64'(use_cnt),       64'd0);

    // Non-contiguous keep: only byte 0 kept, sticky error
    send_beat(8'h60, 8'h05, 1'b0);
    check("pe_k_fill",  64'(dut.fill_q),    64'd9);
    check("pe_k_byte8", 64'(use_data[8]),   64'h60);
    check("pe_k_byte9", 64'(use_data[9]),   64'h00);
    check("perr_set",   64'(perr),          64'd1);
    send_beat(8'h70, 8'hFF, 1'b0);
    check("perr_stick", 64'(perr),          64'd1);
    check("perr_cnt",   64'(use_cnt),       64'd16);
    check("perr_fill",  64'(dut.fill_q),    64'd17);

    // Asynchronous reset between edges
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("ar_tready",  64'(s_axis_tready), 64'd0);
    check("ar_cnt",     64'(use_cnt),       64'd0);
    check("ar_perr",    64'(perr),          64'd0);
    check("ar_eop",     64'(use_eop),       64'd0);
    check("ar_data",    64'(upper_nonzero(0)), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    check("ar_rel_rdy", 64'(s_axis_tready), 64'd1);

    // Empty packet: tlast with tkeep 0 drains straight back to fill
    send_beat(8'h80, 8'h00, 1'b1);
    check("ep_state",   64'(dut.state_q),   64'd1);
    check("ep_tready",  64'(s_axis_tready), 64'd0);
    check("ep_cnt",     64'(use_cnt),       64'd0);
    check("ep_eop",     64'(use_eop),       64'd0);
    tick();
    check("ep_back",    64'(dut.state_q),   64'd0);
    check("ep_rdy",     64'(s_axis_tready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
